// File: rtl/sap_datapath.sv
// sap_datapath: SAP-1 shared-bus datapath executing a 15-bit control word.
// Define SAP_ALU_FLAGS_EN to build the carry/zero flag registers.
module sap_datapath #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [14:0]       ctrl,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [3:0]        opcode,
   output logic [DATA_W-1:0] out_reg,
   output logic [DATA_W-1:0] bus_dbg,
   output logic              bus_conflict,
   output logic              carry_flag,
   output logic              zero_flag
);
   localparam int DEPTH = 1 << ADDR_W;

   logic c_p, e_p, l_p, l_ma, l_md, e_ce, l_r;
   logic l_i, e_i, l_a, e_a, s_u, e_u, l_b, l_o;

   assign c_p  = ctrl[14];
   assign e_p  = ctrl[13];
   assign l_p  = ctrl[12];
   assign l_ma = ~ctrl[11];
   assign l_md = ~ctrl[10];
   assign e_ce = ~ctrl[9];
   assign l_r  = ~ctrl[8];
   assign l_i  = ~ctrl[7];
   assign e_i  = ~ctrl[6];
   assign l_a  = ~ctrl[5];
   assign e_a  = ctrl[4];
   assign s_u  = ctrl[3];
   assign e_u  = ctrl[2];
   assign l_b  = ~ctrl[1];
   assign l_o  = ~ctrl[0];

   logic [ADDR_W-1:0] pc, mar;
   logic [DATA_W-1:0] mdr, ir, a_reg, b_reg;
   logic [DATA_W-1:0] bus, alu, ram_rd;
   logic [DATA_W:0]   alu_full;
   logic [DATA_W-1:0] ram [DEPTH];
   logic              alu_sel, multi_src;

   assign ram_rd  = ram[mar];
   assign opcode  = ir[DATA_W-1 -: 4];
   assign bus_dbg = bus;

   // ALU with one extra MSB: add carry-out, or sub borrow
   always_comb begin
      if (s_u)
         alu_full = {1'b0, a_reg} - {1'b0, b_reg};
      else
         alu_full = {1'b0, a_reg} + {1'b0, b_reg};
   end

   assign alu = alu_full[DATA_W-1:0];

   // Bus mux: highest-priority enabled source drives the bus
   always_comb begin
      bus     = '0;
      alu_sel = 1'b0;
      if (e_ce)
         bus = ram_rd;
      else if (e_i)
         bus = {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
      else if (e_p)
         bus = {{(DATA_W-ADDR_W){1'b0}}, pc};
      else if (e_a)
         bus = a_reg;
      else if (e_u) begin
         bus     = alu;
         alu_sel = 1'b1;
      end
   end

   assign multi_src = ($countones({e_ce, e_i, e_p, e_a, e_u}) > 1);

   // RAM write port; program load takes precedence over ~L_R
   always_ff @(posedge clk) begin
      if (prog_we)
         ram[prog_addr] <= prog_data;
      else if (l_r)
         ram[mar] <= mdr;
   end

   // Register file loads, all sampling the same pre-edge bus value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc           <= '0;
         mar          <= '0;
         mdr          <= '0;
         ir           <= '0;
         a_reg        <= '0;
         b_reg        <= '0;
         out_reg      <= '0;
         bus_conflict <= 1'b0;
      end else begin
         if (l_p)
            pc <= bus[ADDR_W-1:0];
         else if (c_p)
            pc <= pc + ADDR_W'(1);
         if (l_ma) mar     <= bus[ADDR_W-1:0];
         if (l_md) mdr     <= bus;
         if (l_i)  ir      <= bus;
         if (l_a)  a_reg   <= bus;
         if (l_b)  b_reg   <= bus;
         if (l_o)  out_reg <= bus;
         if (multi_src)
            bus_conflict <= 1'b1;
      end
   end

`ifdef SAP_ALU_FLAGS_EN
   // Flags update only when the ALU result is written back into A
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_flag <= 1'b0;
         zero_flag  <= 1'b0;
      end else if (l_a && alu_sel) begin
         carry_flag <= s_u ? ~alu_full[DATA_W] : alu_full[DATA_W];
         zero_flag  <= (alu == '0);
      end
   end
`else
   logic unused_carry;
   assign unused_carry = alu_full[DATA_W];
   assign carry_flag   = 1'b0;
   assign zero_flag    = 1'b0;
`endif

endmodule

// File: tb/tb_sap_datapath.sv
// tb_sap_datapath: directed and random control words against a
// behavioural model of the SAP datapath.
module tb_sap_datapath;
   localparam logic [14:0] IDLE = 15'h0FE3;
   localparam logic [14:0] CP  = 15'h4000, EP = 15'h2000, LP = 15'h1000;
   localparam logic [14:0] LMA = 15'h0800, LMD = 15'h0400, CE = 15'h0200;
   localparam logic [14:0] LR  = 15'h0100, LI = 15'h0080, EI = 15'h0040;
   localparam logic [14:0] LA  = 15'h0020, EA = 15'h0010, SU = 15'h0008;
   localparam logic [14:0] EU  = 15'h0004, LB = 15'h0002, LO = 15'h0001;
`ifdef SAP_ALU_FLAGS_EN
   localparam bit FLG = 1'b1;
`else
   localparam bit FLG = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [14:0] ctrl;
   logic        prog_we;
   logic [3:0]  prog_addr;
   logic [7:0]  prog_data;
   logic [3:0]  opcode;
   logic [7:0]  out_reg, bus_dbg;
   logic        bus_conflict, carry_flag, zero_flag;

   int n_tests = 0;
   int n_fail  = 0;

   sap_datapath dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ctrl         (ctrl),
      .prog_we      (prog_we),
      .prog_addr    (prog_addr),
      .prog_data    (prog_data),
      .opcode       (opcode),
      .out_reg      (out_reg),
      .bus_dbg      (bus_dbg),
      .bus_conflict (bus_conflict),
      .carry_flag   (carry_flag),
      .zero_flag    (zero_flag)
   );

   always #5 clk = ~clk;

   // model state
   logic [7:0] m_ram [16];
   logic [3:0] m_pc, m_mar;
   logic [7:0] m_mdr, m_ir, m_a, m_b, m_out, m_busv;
   bit         m_conf, m_cf, m_zf, m_usel;
   int         m_nsrc;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [14:0] x(input logic [14:0] m);
      return IDLE ^ m;
   endfunction

   task automatic m_reset();
      m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0;
      m_a = 0; m_b = 0; m_out = 0;
      m_conf = 0; m_cf = 0; m_zf = 0;
   endtask

   // bus value from the asserted sources, first in priority order wins
   task automatic m_eval(input logic [14:0] w);
      logic [7:0] src[$];
      int r;
      src = {};
      r = w[3] ? int'(m_a) - int'(m_b) : int'(m_a) + int'(m_b);
      if (!w[9]) src.push_back(m_ram[m_mar]);
      if (!w[6]) src.push_back({4'h0, m_ir[3:0]});
      if (w[13]) src.push_back({4'h0, m_pc});
      if (w[4])  src.push_back(m_a);
      if (w[2])  src.push_back(8'(r & 255));
      m_nsrc = src.size();
      m_busv = (m_nsrc > 0) ? src[0] : 8'h00;
      m_usel = w[2] && (m_nsrc == 1);
   endtask

   task automatic m_step(input logic [14:0] w, input bit we,
                         input logic [3:0] pa, input logic [7:0] pd);
      if (we) m_ram[pa] = pd;
      else if (!w[8]) m_ram[m_mar] = m_mdr;
      if (!w[5] && m_usel) begin
         m_cf = w[3] ? (m_a >= m_b) : ((int'(m_a) + int'(m_b)) > 255);
         m_zf = (m_busv == 8'h00);
      end
      if (!w[11]) m_mar = m_busv[3:0];
      if (!w[10]) m_mdr = m_busv;
      if (!w[7])  m_ir  = m_busv;
      if (!w[5])  m_a   = m_busv;
      if (!w[1])  m_b   = m_busv;
      if (!w[0])  m_out = m_busv;
      if (w[12]) m_pc = m_busv[3:0];
      else if (w[14]) m_pc = m_pc + 4'd1;
      if (m_nsrc > 1) m_conf = 1;
   endtask

   task automatic cyc(input logic [14:0] w, input bit we = 0,
                      input logic [3:0] pa = 0, input logic [7:0] pd = 0,
                      input string tag = "", input int lit = -1);
      @(negedge clk);
      ctrl = w; prog_we = we; prog_addr = pa; prog_data = pd;
      #1;
      m_eval(w);
      check("bus", bus_dbg, m_busv);
      if (lit >= 0) check(tag, bus_dbg, lit);
      @(posedge clk);
      m_step(w, we, pa, pd);
      #1;
      check("out", out_reg, m_out);
      check("opcode", opcode, m_ir[7:4]);
      check("conflict", bus_conflict, m_conf);
      check("carry", carry_flag, FLG & m_cf);
      check("zero", zero_flag, FLG & m_zf);
   endtask

   task automatic set_a(input logic [7:0] v);
      cyc(IDLE, 1, m_mar, v);
      cyc(x(CE | LA));
   endtask

   task automatic set_b(input logic [7:0] v);
      cyc(IDLE, 1, m_mar, v);
      cyc(x(CE | LB));
   endtask

   task automatic set_ir(input logic [7:0] v);
      cyc(IDLE, 1, m_mar, v);
      cyc(x(CE | LI));
   endtask

   task automatic fetch();
      cyc(x(EP | LMA));
      cyc(x(CP));
      cyc(x(CE | LI));
   endtask

   initial begin
      rst_n = 0; ctrl = IDLE; prog_we = 0; prog_addr = 0; prog_data = 0;
      m_reset();
      // RAM loads are honoured while reset is held
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         prog_we = 1; prog_addr = 4'(i); prog_data = 8'($urandom);
         @(posedge clk);
         m_ram[i] = prog_data;
      end
      @(negedge clk);
      prog_we = 0;
      #1;
      check("rst_out", out_reg, 0);
      check("rst_op", opcode, 0);
      check("rst_conf", bus_conflict, 0);
      check("rst_cf", carry_flag, 0);
      check("rst_zf", zero_flag, 0);
      check("rst_bus", bus_dbg, 0);
      rst_n = 1;

      // LDA 9 / ADD A / OUT program
      cyc(IDLE, 1, 4'h0, 8'h49);
      cyc(IDLE, 1, 4'h1, 8'h2A);
      cyc(IDLE, 1, 4'h2, 8'h50);
      cyc(IDLE, 1, 4'h3, 8'h00);
      cyc(IDLE, 1, 4'h9, 8'h07);
      cyc(IDLE, 1, 4'hA, 8'h05);
      fetch();
      cyc(x(EI | LMA));
      cyc(x(CE | LA));
      fetch();
      cyc(x(EI | LMA));
      cyc(x(CE | LB));
      cyc(x(EU | LA));
      fetch();
      cyc(x(EA | LO));
      check("prog_out", out_reg, 8'h0C);
      cyc(x(EP), 0, 0, 0, "prog_pc", 3);
      fetch();
      check("prog_hlt", opcode, 0);

      // subtract and flags
      set_a(8'h03);
      set_b(8'h05);
      cyc(x(SU | EU | LA));
      check("sub_cf", carry_flag, 0);
      check("sub_zf", zero_flag, 0);
      cyc(x(EA), 0, 0, 0, "sub_a", 8'hFE);
      set_a(8'h05);
      set_b(8'h05);
      cyc(x(SU | EU | LA));
      check("sub0_cf", carry_flag, FLG);
      check("sub0_zf", zero_flag, FLG);
      cyc(x(EA), 0, 0, 0, "sub0_a", 8'h00);

      // PC wrap and L_P over C_P
      set_a(8'h0F);
      cyc(x(EA | LP));
      cyc(x(CP));
      cyc(x(EP), 0, 0, 0, "pc_wrap", 0);
      set_ir(8'h76);
      cyc(x(EI | LP | CP));
      cyc(x(EP), 0, 0, 0, "pc_lp", 6);

      // STA path and program-load override
      set_a(8'h42);
      set_ir(8'h0E);
      cyc(x(EI | LMA));
      cyc(x(EA | LMD), 1, 4'hE, 8'hA5);
      cyc(x(LR));
      cyc(x(CE | LB), 0, 0, 0, "sta_rd", 8'h42);
      cyc(x(LB | EU), 0, 0, 0, "sta_b", 8'h84);
      cyc(x(LR), 1, 4'hE, 8'h11);
      cyc(x(CE), 0, 0, 0, "we_win", 8'h11);

      // bus conflict is sticky
      set_ir(8'h02);
      cyc(x(EI | LP));
      set_a(8'h99);
      check("conf0", bus_conflict, 0);
      cyc(x(EA | EP), 0, 0, 0, "conf_bus", 2);
      check("conf1", bus_conflict, 1);
      repeat (3) cyc(IDLE);
      check("conf_hold", bus_conflict, 1);

      // mid-run reset
      set_a(8'h55);
      set_ir(8'h07);
      cyc(x(EI | LP));
      @(negedge clk);
      rst_n = 0; ctrl = x(EA);
      m_reset();
      #1;
      check("mrst_out", out_reg, 0);
      check("mrst_op", opcode, 0);
      check("mrst_conf", bus_conflict, 0);
      check("mrst_a", bus_dbg, 0);
      ctrl = x(EP);
      #1;
      check("mrst_pc", bus_dbg, 0);
      @(negedge clk);
      rst_n = 1; ctrl = IDLE;
      for (int i = 0; i < 16; i++) begin
         cyc(x(EP | LMA | CP));
         cyc(x(CE));
      end

      // random control words
      for (int i = 0; i < 400; i++) begin
         cyc(15'($urandom), ($urandom_range(0, 7) == 0),
             4'($urandom), 8'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
